// File: rtl/mmio_ctrl_if.sv
// CPU data-memory side bus between the core and the MMIO register block.
interface mmio_ctrl_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] mem_addr;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;
    logic             io_sel;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  mem_rdata, io_sel
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output mem_rdata, io_sel
    );
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped KEY/SW inputs with sticky status, LED/HEX output registers
// and an interval timer on the CPU data bus.
module mmio_ctrl #(
    parameter int unsigned    DBITS           = 32,
    parameter int unsigned    NUM_KEYS        = 4,
    parameter int unsigned    NUM_SW          = 10,
    parameter int unsigned    NUM_LEDR        = 10,
    parameter int unsigned    NUM_LEDG        = 8,
    parameter int unsigned    NUM_HEX         = 4,
    parameter int unsigned    DEBOUNCE_CYCLES = 16,
    parameter int unsigned    TIMER_PRESCALE  = 50000,
    parameter logic [DBITS-1:0] ADDR_HEX      = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR     = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG     = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW       = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_TCNT     = 32'hF0000020,
    parameter logic [DBITS-1:0] ADDR_TLIM     = 32'hF0000024,
    parameter logic [DBITS-1:0] ADDR_KCTRL    = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_TCTRL    = 32'hF0000120
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_ctrl_if.slave            bus,
    input  logic [NUM_KEYS-1:0]   KEY,
    input  logic [NUM_SW-1:0]     SW,
    output logic [NUM_LEDR-1:0]   LEDR,
    output logic [NUM_LEDG-1:0]   LEDG,
    output logic [7*NUM_HEX-1:0]  HEX
);
    localparam int unsigned NIN = NUM_KEYS + NUM_SW;
    localparam int unsigned CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW  = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam int unsigned HW  = 4 * NUM_HEX;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [NIN-1:0]          sync1, sync2, deb, flip;
    logic [NIN-1:0][CW-1:0]  cnt;
    logic [HW-1:0]           hex_reg;
    logic [7*NUM_HEX-1:0]    hex_seg_n;
    logic [DBITS-1:0]        tcnt, tlim;
    logic [PW-1:0]           pcnt;
    logic                    k_rdy, k_ovr, t_rdy, t_ovr;
    logic                    k_rdy_n, k_ovr_n, t_rdy_n, t_ovr_n;
    logic                    key_evt, t_run, t_tick, t_wrap;
    logic                    rd_key, wr_hex, wr_ledr, wr_ledg, wr_tcnt, wr_tlim, wr_kctrl, wr_tctrl;
    logic [DBITS-1:0]        rdata_c;
    logic                    sel_c;

    assign rd_key   = bus.mem_rd_en && (bus.mem_addr == ADDR_KEY);
    assign wr_hex   = bus.mem_wr_en && (bus.mem_addr == ADDR_HEX);
    assign wr_ledr  = bus.mem_wr_en && (bus.mem_addr == ADDR_LEDR);
    assign wr_ledg  = bus.mem_wr_en && (bus.mem_addr == ADDR_LEDG);
    assign wr_tcnt  = bus.mem_wr_en && (bus.mem_addr == ADDR_TCNT);
    assign wr_tlim  = bus.mem_wr_en && (bus.mem_addr == ADDR_TLIM);
    assign wr_kctrl = bus.mem_wr_en && (bus.mem_addr == ADDR_KCTRL);
    assign wr_tctrl = bus.mem_wr_en && (bus.mem_addr == ADDR_TCTRL);

    // A bit flips on the edge its counter would reach DEBOUNCE_CYCLES differing samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NIN; i++)
            flip[i] = (sync2[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end

    assign key_evt = |flip[NUM_KEYS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {SW, ~KEY};
            sync2 <= sync1;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Timer: prescaler held at 0 while stopped; a TCNT write takes priority over a tick.
    assign t_run  = (tlim != '0);
    assign t_tick = t_run && (pcnt == PW'(TIMER_PRESCALE - 1));
    assign t_wrap = t_tick && !wr_tcnt && (tcnt == tlim - DBITS'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
            tlim <= '0;
            pcnt <= '0;
        end else begin
            if (wr_tcnt) begin
                tcnt <= bus.mem_wdata;
                pcnt <= '0;
            end else begin
                pcnt <= (!t_run || t_tick) ? '0 : pcnt + PW'(1);
                if (t_tick)
                    tcnt <= t_wrap ? '0 : tcnt + DBITS'(1);
            end
            if (wr_tlim)
                tlim <= bus.mem_wdata;
        end
    end

    // Sticky status: hardware set wins over software clear; write 1 is a no-op.
    always_comb begin
        k_rdy_n = k_rdy;
        k_ovr_n = k_ovr;
        t_rdy_n = t_rdy;
        t_ovr_n = t_ovr;
        if (rd_key)                             k_rdy_n = 1'b0;
        if (wr_kctrl && !bus.mem_wdata[0])      k_rdy_n = 1'b0;
        if (wr_kctrl && !bus.mem_wdata[1])      k_ovr_n = 1'b0;
        if (wr_tctrl && !bus.mem_wdata[0])      t_rdy_n = 1'b0;
        if (wr_tctrl && !bus.mem_wdata[1])      t_ovr_n = 1'b0;
        if (key_evt) begin
            k_rdy_n = 1'b1;
            if (k_rdy) k_ovr_n = 1'b1;
        end
        if (t_wrap) begin
            t_rdy_n = 1'b1;
            if (t_rdy) t_ovr_n = 1'b1;
        end
    end

    always_comb begin
        hex_seg_n = '0;
        for (int i = 0; i < NUM_HEX; i++)
            hex_seg_n[7*i +: 7] = seg7(bus.mem_wdata[4*i +: 4]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_rdy   <= 1'b0;
            k_ovr   <= 1'b0;
            t_rdy   <= 1'b0;
            t_ovr   <= 1'b0;
            hex_reg <= '0;
            HEX     <= {NUM_HEX{7'b1000000}};
            LEDR    <= '0;
            LEDG    <= '0;
        end else begin
            k_rdy <= k_rdy_n;
            k_ovr <= k_ovr_n;
            t_rdy <= t_rdy_n;
            t_ovr <= t_ovr_n;
            if (wr_hex) begin
                hex_reg <= bus.mem_wdata[HW-1:0];
                HEX     <= hex_seg_n;
            end
            if (wr_ledr) LEDR <= bus.mem_wdata[NUM_LEDR-1:0];
            if (wr_ledg) LEDG <= bus.mem_wdata[NUM_LEDG-1:0];
        end
    end

    // Combinational read mux; unmapped addresses deselect and return zero.
    always_comb begin
        rdata_c = '0;
        sel_c   = 1'b1;
        case (bus.mem_addr)
            ADDR_HEX:   rdata_c = DBITS'(hex_reg);
            ADDR_LEDR:  rdata_c = DBITS'(LEDR);
            ADDR_LEDG:  rdata_c = DBITS'(LEDG);
            ADDR_KEY:   rdata_c = DBITS'(deb[NUM_KEYS-1:0]);
            ADDR_SW:    rdata_c = DBITS'(deb[NIN-1:NUM_KEYS]);
            ADDR_TCNT:  rdata_c = tcnt;
            ADDR_TLIM:  rdata_c = tlim;
            ADDR_KCTRL: rdata_c = DBITS'({k_ovr, k_rdy});
            ADDR_TCTRL: rdata_c = DBITS'({t_ovr, t_rdy});
            default:    sel_c   = 1'b0;
        endcase
    end

    assign bus.mem_rdata = rdata_c;
    assign bus.io_sel    = sel_c;
endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboard bench for mmio_ctrl: expected register values are queued as
// stimulus is applied and checked as each read or output sample is taken.
module tb_mmio_ctrl;
    localparam int unsigned D  = 8;
    localparam int unsigned PS = 4;
    localparam logic [31:0] A_HEX   = 32'hF0000000;
    localparam logic [31:0] A_LEDR  = 32'hF0000004;
    localparam logic [31:0] A_LEDG  = 32'hF0000008;
    localparam logic [31:0] A_KEY   = 32'hF0000010;
    localparam logic [31:0] A_TCNT  = 32'hF0000020;
    localparam logic [31:0] A_TLIM  = 32'hF0000024;
    localparam logic [31:0] A_KCTRL = 32'hF0000110;
    localparam logic [31:0] A_TCTRL = 32'hF0000120;
    localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [27:0] hex;

    mmio_ctrl_if #(.DBITS(32)) bus ();

    mmio_ctrl #(.DEBOUNCE_CYCLES(D), .TIMER_PRESCALE(PS)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .KEY(key), .SW(sw), .LEDR(ledr), .LEDG(ledg), .HEX(hex)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;
    logic        sel;

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d, output logic s);
        bus.mem_addr = a; #1; d = bus.mem_rdata; s = bus.io_sel;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.mem_addr = a; bus.mem_rd_en = 1'b1; #1; d = bus.mem_rdata;
        tick(); bus.mem_rd_en = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wr_en = 1'b1;
        tick(); bus.mem_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; key = 4'hF; sw = '0;
        bus.mem_addr = '0; bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0; bus.mem_wdata = '0;
        tick(3); reset = 1'b1; tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'(HEX_ZERO));
        got = 32'(ledr); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_ledr got=%h want=%h", got, exp); end
        got = 32'(ledg); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_ledg got=%h want=%h", got, exp); end
        got = 32'(hex); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_hex got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_kctrl got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_TCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_tctrl got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); peek(32'h00001000, got, sel);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL unmapped_rdata got=%h want=%h", got, exp); end
        exp = exp_q.pop_front(); n_cmp++;
        if (32'(sel) !== exp) begin n_fail++; $display("FAIL unmapped_sel got=%b want=%h", sel, exp); end
    endtask

    task automatic test_outputs();
        bus_wr(A_HEX, 32'h0000BEEF);
        exp_q.push_back(32'({7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}));
        got = 32'(hex); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL hex_segments got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0000BEEF); peek(A_HEX, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL hex_readback got=%h want=%h", got, exp); end
        bus_wr(A_LEDR, 32'h3FF);
        exp_q.push_back(32'h3FF); got = 32'(ledr); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ledr_pins got=%h want=%h", got, exp); end
        exp_q.push_back(32'h3FF); peek(A_LEDR, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ledr_readback got=%h want=%h", got, exp); end
        bus_wr(A_LEDG, 32'hFFFF_F1A5);
        exp_q.push_back(32'hA5); peek(A_LEDG, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ledg_width got=%h want=%h", got, exp); end
        bus_wr(A_KEY, 32'hF);
        exp_q.push_back(32'h0); peek(A_KEY, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL key_write_ignored got=%h want=%h", got, exp); end
    endtask

    task automatic test_debounce();
        key[0] = 1'b0; tick(D - 1); key[0] = 1'b1; tick(D + 4);
        exp_q.push_back(32'h0); peek(A_KEY, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL glitch_key got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL glitch_kctrl got=%h want=%h", got, exp); end
        key[0] = 1'b0; tick(D + 1);
        exp_q.push_back(32'h0); peek(A_KEY, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL deb_early got=%h want=%h", got, exp); end
        tick();
        exp_q.push_back(32'h1); peek(A_KEY, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL deb_latency got=%h want=%h", got, exp); end
        exp_q.push_back(32'h1); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL deb_ready got=%h want=%h", got, exp); end
    endtask

    task automatic test_key_status();
        key[0] = 1'b1; tick(D + 3);
        exp_q.push_back(32'h3); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL key_overrun got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); bus_rd(A_KEY, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL key_released got=%h want=%h", got, exp); end
        exp_q.push_back(32'h2); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL read_clears_ready got=%h want=%h", got, exp); end
        bus_wr(A_KCTRL, 32'h0);
        exp_q.push_back(32'h0); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL w0c_kctrl got=%h want=%h", got, exp); end
        key[1] = 1'b0; tick(D + 1); bus_wr(A_KCTRL, 32'h0);
        exp_q.push_back(32'h1); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL set_beats_clear got=%h want=%h", got, exp); end
        key[1] = 1'b1; tick(D + 1);
        exp_q.push_back(32'h2); bus_rd(A_KEY, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL coincident_read_data got=%h want=%h", got, exp); end
        exp_q.push_back(32'h3); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL set_beats_read got=%h want=%h", got, exp); end
    endtask

    task automatic test_timer();
        bus_wr(A_TLIM, 32'd3); bus_wr(A_TCNT, 32'd0);
        for (int k = 0; k < 16; k++) exp_q.push_back(32'((k / PS) % 3));
        for (int k = 0; k < 16; k++) begin
            peek(A_TCNT, got, sel); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL tcnt_seq[%0d] got=%h want=%h", k, got, exp); end
            tick();
        end
        exp_q.push_back(32'h1); peek(A_TCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL timer_ready got=%h want=%h", got, exp); end
        tick(9);
        exp_q.push_back(32'h3); peek(A_TCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL timer_overrun got=%h want=%h", got, exp); end
        bus_wr(A_TLIM, 32'd0); bus_wr(A_TCNT, 32'd5); tick(10);
        exp_q.push_back(32'd5); peek(A_TCNT, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL timer_stopped got=%h want=%h", got, exp); end
        bus_wr(A_TCTRL, 32'h0);
        exp_q.push_back(32'h0); peek(A_TCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL w0c_tctrl got=%h want=%h", got, exp); end
        bus_wr(A_TLIM, 32'd3); bus_wr(A_TCNT, 32'hFFFF_FFFF); tick(PS - 1);
        exp_q.push_back(32'hFFFF_FFFF); peek(A_TCNT, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL tcnt_above_lim got=%h want=%h", got, exp); end
        tick();
        exp_q.push_back(32'h0); peek(A_TCNT, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL tcnt_rollover got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_TCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL rollover_no_ready got=%h want=%h", got, exp); end
        bus_wr(A_TCNT, 32'd2);
    endtask

    task automatic test_async_reset();
        key[2] = 1'b0; tick(5); #2;
        reset = 1'b0; #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'(HEX_ZERO));
        got = 32'(ledr); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL async_ledr got=%h want=%h", got, exp); end
        got = 32'(hex); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL async_hex got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_TCNT, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL async_tcnt got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL async_kctrl got=%h want=%h", got, exp); end
        key[2] = 1'b1; tick(3); reset = 1'b1; tick(D + 4);
        exp_q.push_back(32'h0); peek(A_KEY, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL post_reset_key got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0); peek(A_KCTRL, got, sel); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL post_reset_kctrl got=%h want=%h", got, exp); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_outputs();
        test_debounce();
        test_key_status();
        test_timer();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
Parametrised memory-mapped I/O controller for the CPU data-memory path. It replaces ad-hoc KEY/SW/HEX/LEDR/LEDG glue with three kinds of register: debounced inputs with sticky event/overrun status, output registers, and an interval timer. The CPU top instantiates it beside data memory and uses io_sel to choose between memory read data and mem_rdata.

Parameters:
DBITS, 32, bus data/address width
NUM_KEYS, 4, push-button count (board KEY pins are active-low)
NUM_SW, 10, switch count
NUM_LEDR, 10, red LED count
NUM_LEDG, 8, green LED count
NUM_HEX, 4, seven-segment digits; HEX register uses 4*NUM_HEX bits
DEBOUNCE_CYCLES, 16, stable cycles required before a debounced input changes
TIMER_PRESCALE, 50000, clocks per timer tick
ADDR_HEX, 32'hF0000000, HEX data register
ADDR_LEDR, 32'hF0000004, LEDR data register
ADDR_LEDG, 32'hF0000008, LEDG data register
ADDR_KEY, 32'hF0000010, KEY data register (RO)
ADDR_SW, 32'hF0000014, SW data register (RO)
ADDR_TCNT, 32'hF0000020, timer count register
ADDR_TLIM, 32'hF0000024, timer limit register
ADDR_KCTRL, 32'hF0000110, key status register
ADDR_TCTRL, 32'hF0000120, timer status register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (reset asserted when low)
mem_addr  in  DBITS  byte address from CPU
mem_rd_en  in  1  read strobe; read side effects occur at the clk edge
mem_wr_en  in  1  write strobe
mem_wdata  in  DBITS  write data
mem_rdata  out  DBITS  combinational read data
io_sel  out  1  high when mem_addr matches any register in the map
KEY  in  NUM_KEYS  raw push-buttons, active-low
SW  in  NUM_SW  raw switches
LEDR  out  NUM_LEDR  red LEDs
LEDG  out  NUM_LEDG  green LEDs
HEX  out  7*NUM_HEX  segments, active-low; digit i occupies bits [7i+6:7i]

Behaviour:
- Reset (async): all registers, counters and status bits go to 0; LEDR=0; LEDG=0; every HEX digit shows '0' (7'b1000000).
- Input path: KEY is inverted (1=pressed). KEY and SW each pass through a 2-flop synchroniser, then a per-bit debounce counter. The debounced bit takes the new value only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised value. Any glitch resets that bit's counter.
- Latency: 2 synchroniser cycles + DEBOUNCE_CYCLES from a stable raw change to the debounced change.
- Reads are combinational on mem_addr. An unmapped address returns 0 with io_sel=0. Unused upper bits read as 0.
- KEY read: returns the debounced keys.
- KCTRL: bit0=ready, bit1=overrun.
  - Any change in the debounced key vector sets ready. If ready is already 1, the change also sets overrun.
  - A mem_rd_en read of ADDR_KEY clears ready.
  - A write to KCTRL with wdata bit0=0 clears ready; with bit1=0 it clears overrun. Writing 1 to either bit has no effect.
- SW read: returns the debounced switches. It has no status register and no side effects.
- HEX, LEDR, LEDG: read/write. A write updates the register on the same edge and the output changes that cycle. HEX decodes each nibble 0-F to the standard active-low segment patterns.
- Timer:
  - The prescaler counts 0..TIMER_PRESCALE-1 and emits a one-cycle tick on wrap.
  - If TLIM==0, the timer is stopped: TCNT holds and the prescaler is held at 0.
  - On a tick: if TCNT==TLIM-1, TCNT becomes 0 and TCTRL.ready is set (overrun is also set if ready was already 1). Otherwise TCNT increments.
  - A write to TCNT loads it and resets the prescaler. A write to TLIM loads it without touching TCNT.
  - If TCNT>=TLIM after a write, TCNT counts up to 2^DBITS-1 and wraps to 0 with no ready set. It then behaves normally.
  - TCTRL write-0-to-clear semantics are the same as KCTRL.
- Simultaneous events:
  - A hardware set (key event or timer wrap) in the same cycle as a software clear: the set wins, so ready=1. Overrun is set only if ready was 1 before that cycle.
  - A read of KEY in the same cycle as a key event leaves ready=1.
  - mem_wr_en and mem_rd_en together: both take effect.
- Writes to KEY and SW are ignored.
- Reset asserted mid-debounce or mid-count aborts the operation immediately with no pending events retained.

Test Plan:
- Reset: release reset -> LEDR=0, LEDG=0, every HEX digit is 7'b1000000, KCTRL/TCTRL read 0, unmapped 32'h00001000 gives io_sel=0 and rdata=0.
- Output registers: write 32'h0000BEEF to ADDR_HEX -> digits 3..0 show B,E,E,F patterns the cycle after; write 32'h3FF to LEDR -> all red LEDs lit, readback 32'h3FF.
- Debounce: KEY[0] low for DEBOUNCE_CYCLES-1 cycles then bounce high -> no change. Hold low for 2+DEBOUNCE_CYCLES cycles -> KEY reads 32'h1 and KCTRL reads 32'h1.
- Key status: press then release without reading -> KCTRL=32'h3. Read KEY -> KCTRL=32'h2. Write 0 to KCTRL -> 0. Key event coincident with a KCTRL clear -> KCTRL=32'h1.
- Timer (TIMER_PRESCALE=4 in bench): TLIM=3 -> TCNT goes 0,1,2,0 every 4 cycles and TCTRL=1 after the first wrap. Leave unread through a second wrap -> TCTRL=3. TLIM=0 -> TCNT holds.
- Async reset mid-operation: assert reset mid-debounce with the timer running -> all outputs and status are 0 immediately, without waiting for a clk edge.
